ps2_rx_frame: RTL and testbench

- PS/2 receive front end: deserialises keyboard scan-code frames from the raw ps2_clk/ps2_data pins.
- Presents a 16-bit rolling keycode window: previous byte in [15:8], newest byte in [7:0].
- Sits directly upstream of the keyboard control stage, which decodes make/break (F0-prefixed) codes into button levels.
- Handles synchronisation, glitch filtering, framing/parity checking and a stuck-frame watchdog.

---
 rtl/keyboard_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 40 ++++
 rtl/ps2_rx_frame.sv | 122 ++++++++++++
 tb/tb_ps2_rx_frame.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared PS/2 keyboard definitions: receiver state encoding and scan-code constants
// used by the receive front end and the downstream keyboard control stage.
package keyboard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam int         PS2_DATA_BITS = 8;

  // Set-2 arrow scan codes (sent behind the E0 prefix).
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_RIGHT = 8'h74;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, sample-history glitch filter and falling-edge detector
// for one asynchronous PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic                  sync1;
  logic                  sync2;
  logic [FILTER_LEN-1:0] hist;
  logic                  level_q;

  // The level only moves once the whole history agrees, so short pulses are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      hist    <= '1;
      level   <= 1'b1;
      level_q <= 1'b1;
    end else begin
      sync1   <= pin;
      sync2   <= sync1;
      hist    <= {hist[FILTER_LEN-2:0], sync2};
      if (hist == '0)
        level <= 1'b0;
      else if (hist == '1)
        level <= 1'b1;
      level_q <= level;
    end
  end

  assign fall = level_q & ~level;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: frames 11-bit scan-code packets into a rolling
// {previous, newest} keycode window, with parity/stop checking and a watchdog.
module ps2_rx_frame
  import keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        keycode_valid,
  output logic        frame_error
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t        state;
  rx_state_t        next_state;
  logic             clk_level;
  logic             fall;
  logic             data_sync1;
  logic             data_sync2;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             parity_bit;
  logic [WD_W-1:0]  wd_cnt;
  logic             timeout;
  logic             frame_ok;
  logic             set_valid;
  logic             set_err;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (ps2_clk),
    .level (clk_level),
    .fall  (fall)
  );

  // Data is far faster through its path than the filtered clock, so it is settled at fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync1 <= 1'b1;
      data_sync2 <= 1'b1;
    end else begin
      data_sync1 <= ps2_data;
      data_sync2 <= data_sync1;
    end
  end

  // A fall in the same cycle as the terminal count wins.
  assign timeout = (state != IDLE) && !fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (timeout) begin
      next_state = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:    if (!data_sync2) next_state = DATA;
        DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
        PARITY:  next_state = STOP;
        STOP:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ok  = data_sync2 && (^{shift, parity_bit});
    set_valid = fall && (state == STOP) && frame_ok;
    set_err   = timeout || (fall && (state == STOP) && !frame_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= 3'd0;
      shift         <= 8'h00;
      parity_bit    <= 1'b0;
      keycode       <= 16'h0000;
      keycode_valid <= 1'b0;
      frame_error   <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      keycode_valid <= set_valid;
      frame_error   <= set_err;
      if (set_valid)
        keycode <= {keycode[7:0], shift};

      if (fall || state == IDLE || timeout)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;

      if (fall && !timeout) begin
        unique case (state)
          IDLE: begin
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
          end
          DATA: begin
            shift   <= {data_sync2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  parity_bit <= data_sync2;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: bit-bangs PS/2 frames on the raw pins and
// checks the keycode window and pulse counts against hand-computed values.
module tb_ps2_rx_frame;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;

  logic        clk;
  logic        rst_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] keycode;
  logic        keycode_valid;
  logic        frame_error;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_both   = 0;
  int v0;
  int e0;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .keycode       (keycode),
    .keycode_valid (keycode_valid),
    .frame_error   (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (keycode_valid) n_valid++;
    if (frame_error) n_ferr++;
    if (keycode_valid && frame_error) n_both++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic mark();
    v0 = n_valid;
    e0 = n_ferr;
  endtask

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_keycode", keycode, 16'h0000);
    check("reset_valid", 16'(keycode_valid), 16'h0);
    check("reset_error", 16'(frame_error), 16'h0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // 0x1C, parity 0
    mark();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("1c_keycode", keycode, 16'h001C);
    check("1c_valid_cnt", 16'(n_valid - v0), 16'd1);
    check("1c_err_cnt", 16'(n_ferr - e0), 16'd0);

    // F0 then 1C
    mark();
    send_frame(8'hF0, odd_par(8'hF0), 1'b1);
    check("f0_keycode", keycode, 16'h1CF0);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    check("f01c_keycode", keycode, 16'hF01C);
    check("f01c_valid_cnt", 16'(n_valid - v0), 16'd2);

    // 0x23 with wrong parity, then correct
    mark();
    send_frame(8'h23, 1'b1, 1'b1);
    check("badpar_err_cnt", 16'(n_ferr - e0), 16'd1);
    check("badpar_valid_cnt", 16'(n_valid - v0), 16'd0);
    check("badpar_keycode", keycode, 16'hF01C);
    send_frame(8'h23, 1'b0, 1'b1);
    check("goodpar_keycode", keycode, 16'h1C23);

    // stop bit 0
    mark();
    send_frame(8'h1C, 1'b0, 1'b0);
    check("badstop_err_cnt", 16'(n_ferr - e0), 16'd1);
    check("badstop_valid_cnt", 16'(n_valid - v0), 16'd0);
    check("badstop_keycode", keycode, 16'h1C23);

    // partial frame, watchdog abort, then clean frame
    mark();
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TIMEOUT_CYCLES + 10) @(posedge clk);
    @(negedge clk);
    check("timeout_err_cnt", 16'(n_ferr - e0), 16'd1);
    check("timeout_valid_cnt", 16'(n_valid - v0), 16'd0);
    send_frame(8'h23, odd_par(8'h23), 1'b1);
    check("post_timeout_keycode", keycode, 16'h2323);

    // short low glitch in IDLE
    mark();
    @(posedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("glitch_pulses", 16'((n_valid - v0) + (n_ferr - e0)), 16'd0);
    check("glitch_keycode", keycode, 16'h2323);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    check("post_glitch_keycode", keycode, 16'h231C);

    // reset in the middle of a frame
    mark();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_keycode", keycode, 16'h0000);
    check("midrst_valid", 16'(keycode_valid), 16'h0);
    check("midrst_error", 16'(frame_error), 16'h0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("midrst_pulses", 16'((n_valid - v0) + (n_ferr - e0)), 16'd0);
    mark();
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    check("post_rst_keycode", keycode, 16'h001C);
    check("post_rst_valid_cnt", 16'(n_valid - v0), 16'd1);

    check("never_both", 16'(n_both), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
